xpm_sp_distram_arb: RTL and testbench
=====================================

// Module: xpm_sp_distram_arb
// PURPOSE
//  Arbitrating controller in front of one single-port bit-write-enable distributed RAM (read latency 1).
//  Shares the RAM between two requesters (A, B) with valid/ready request handshakes and round-robin fairness.
//  Returns read data on per-requester response strobes.
//  Optionally clears the whole RAM after reset before accepting traffic.
// PARAMETERS
//  MEM_DATAWIDTH  128  RAM word width; also width of bit-wise write mask
//  MEM_ADDRWIDTH  14   RAM address width; depth = 2**MEM_ADDRWIDTH
// PORTS (x = a | b, one set per requester)
//  clk            in   1    single clock
//  reset_n        in   1    asynchronous, active-low reset
//  x_req_valid    in   1    request present
//  x_req_ready    out  1    request accepted this cycle (valid && ready)
//  x_req_wr       in   1    1 = write, 0 = read
//  x_req_addr     in   AW   word address
//  x_req_be       in   DW   bit-wise write mask (ignored on reads)
//  x_req_data     in   DW   write data
//  x_rsp_valid    out  1    read data valid, 1-cycle strobe, no backpressure
//  x_rsp_data     out  DW   read data; 0 when x_rsp_valid = 0
//  ram_en         out  1    to RAM ena
//  ram_we         out  DW   to RAM bit-wise we
//  ram_addr       out  AW   to RAM addr
//  ram_din        out  DW   to RAM din
//  ram_dout       in   DW   from RAM dout, valid the cycle after a read
//  init_done      out  1    1 once RAM ready for traffic
// BEHAVIOUR
//  Reset values: all x_req_ready 0, x_rsp_valid 0, x_rsp_data 0, ram_en 0, ram_we 0; init_done 0 (1 without clear).
//  States: CLEAR -> RUN. Reset enters CLEAR with clear feature, RUN without it.
//  CLEAR:
//   - ram_en 1, ram_we all-ones, ram_din 0, ram_addr = clr_cnt
//   - clr_cnt increments 0 .. 2**AW-1; at max wraps to 0 and enters RUN
//   - init_done registered 1 from the first RUN cycle; no ready asserted in CLEAR
//  RUN arbitration, combinational grant:
//   - only one valid: that requester granted
//   - both valid: requester != last_gnt granted
//   - last_gnt is a register, resets to B (A wins first contention), updates on every grant
//   - x_req_ready = grant; ready may depend on valid
//  RAM drive on grant:
//   - ram_en 1; ram_addr/ram_din from granted requester
//   - ram_we = wr ? be : 0
//   - no grant: ram_en 0, ram_we 0
//   - writes with be = 0 still consume the slot; no write response
//  Read response:
//   - pend_valid/pend_id registered on read grant
//   - next cycle: x_rsp_valid = pend_valid && pend_id == x; x_rsp_data = ram_dout, else 0
//   - throughput 1 request/cycle total; back-to-back reads pipeline
//  Ordering:
//   - write at cycle N, read same address at N+1 (either requester) returns new data
//   - a same-cycle read/write conflict is impossible (single grant)
//  Reset mid-operation (async): in-flight response dropped, CLEAR restarts at address 0, last_gnt back to B.
// CONFIGURATION
//  `define XPM_SP_DISTRAM_ARB_CLEAR_EN: CLEAR state, clr_cnt and init_done sequencing included.
//  Without it: RAM content undefined after reset, state starts RUN, init_done constant 1, traffic accepted from first edge after reset release.
// STRUCTURE
//  Package distram_arb_pkg:
//   - typedef enum {ST_CLEAR, ST_RUN} state_t
//   - localparams REQ_A = 1'b0, REQ_B = 1'b1
//  Sub-module distram_rr_arb2: 2-way round-robin grant + last_gnt register. Top keeps FSM, clear counter, RAM mux, response pipe.
// TESTING (DW=8, AW=4, clear on unless noted)
//  1. Release reset, no traffic -> 16 cycles ram_en=1, ram_we=8'hFF, ram_din=0, addr 0..15; init_done 1 next cycle; read addr 5 -> a_rsp_data=8'h00.
//  2. A write addr 3 data 8'hA5 be 8'hFF, next cycle B read addr 3 -> b_rsp_valid 1 cycle later, b_rsp_data=8'hA5, a_rsp_valid 0.
//  3. Masked write addr 3 data 8'h0F be 8'h0F over 8'hA5, then read -> 8'hAF.
//  4. A and B valid reads held 6 cycles -> grants A,B,A,B,A,B; rsp strobes alternate one cycle behind; no idle cycle.
//  5. Reset_n low mid read burst -> all outputs 0 asynchronously; after release CLEAR reruns from addr 0; no stale rsp_valid.
//  6. Clear macro undefined -> init_done 1 in reset; A read addr 0 accepted on first cycle after release.

Source files
------------

// File: rtl/distram_arb_pkg.sv
// rtl/distram_arb_pkg.sv - shared types and requester ids for the distributed RAM arbiter
package distram_arb_pkg;

   // Controller phases: CLEAR wipes the RAM after reset, RUN serves requesters
   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   // Requester identifiers used for last-grant tracking and response routing
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/distram_rr_arb2.sv
// rtl/distram_rr_arb2.sv - two-way round-robin grant with last-grant register
module distram_rr_arb2
   import distram_arb_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   input  logic a_valid,
   input  logic b_valid,
   output logic a_gnt,
   output logic b_gnt
);

   logic last_gnt_q;

   // Single requester wins outright; on contention the one not served last wins
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (enable) begin
         if (a_valid && b_valid) begin
            a_gnt = (last_gnt_q == REQ_B);
            b_gnt = (last_gnt_q == REQ_A);
         end else begin
            a_gnt = a_valid;
            b_gnt = b_valid;
         end
      end
   end

   // Remember who was served last; B after reset so A wins the first contention
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_q <= REQ_B;
      end else if (a_gnt) begin
         last_gnt_q <= REQ_A;
      end else if (b_gnt) begin
         last_gnt_q <= REQ_B;
      end
   end

endmodule

// File: rtl/xpm_sp_distram_arb.sv
// rtl/xpm_sp_distram_arb.sv - two-requester arbiter for a single-port distributed RAM (optional clear: XPM_SP_DISTRAM_ARB_CLEAR_EN)
module xpm_sp_distram_arb
   import distram_arb_pkg::*;
#(
   parameter int MEM_DATAWIDTH = 128,
   parameter int MEM_ADDRWIDTH = 14
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     a_req_valid,
   output logic                     a_req_ready,
   input  logic                     a_req_wr,
   input  logic [MEM_ADDRWIDTH-1:0] a_req_addr,
   input  logic [MEM_DATAWIDTH-1:0] a_req_be,
   input  logic [MEM_DATAWIDTH-1:0] a_req_data,
   output logic                     a_rsp_valid,
   output logic [MEM_DATAWIDTH-1:0] a_rsp_data,
   input  logic                     b_req_valid,
   output logic                     b_req_ready,
   input  logic                     b_req_wr,
   input  logic [MEM_ADDRWIDTH-1:0] b_req_addr,
   input  logic [MEM_DATAWIDTH-1:0] b_req_be,
   input  logic [MEM_DATAWIDTH-1:0] b_req_data,
   output logic                     b_rsp_valid,
   output logic [MEM_DATAWIDTH-1:0] b_rsp_data,
   output logic                     ram_en,
   output logic [MEM_DATAWIDTH-1:0] ram_we,
   output logic [MEM_ADDRWIDTH-1:0] ram_addr,
   output logic [MEM_DATAWIDTH-1:0] ram_din,
   input  logic [MEM_DATAWIDTH-1:0] ram_dout,
   output logic                     init_done
);

   localparam int DW = MEM_DATAWIDTH;
   localparam int AW = MEM_ADDRWIDTH;

   state_t          state_q;
   logic [AW-1:0]   clr_addr;
   logic            clr_active;
   logic            run_active;
   logic            a_gnt;
   logic            b_gnt;
   logic            pend_valid_q;
   logic            pend_id_q;

`ifdef XPM_SP_DISTRAM_ARB_CLEAR_EN
   state_t          state_d;
   logic [AW-1:0]   clr_cnt_q;
   logic            init_done_q;

   // Phase register: every reset restarts the wipe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_CLEAR;
      end else begin
         state_q <= state_d;
      end
   end

   // Leave CLEAR once the last address has been written
   always_comb begin
      state_d = state_q;
      if ((state_q == ST_CLEAR) && (clr_cnt_q == {AW{1'b1}})) begin
         state_d = ST_RUN;
      end
   end

   // Clear address walks the whole RAM and wraps back to 0 on exit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_cnt_q <= '0;
      end else if (state_q == ST_CLEAR) begin
         clr_cnt_q <= clr_cnt_q + 1'b1;
      end
   end

   // Ready flag goes high together with the first RUN cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         init_done_q <= 1'b0;
      end else begin
         init_done_q <= (state_d == ST_RUN);
      end
   end

   assign clr_addr  = clr_cnt_q;
   assign init_done = init_done_q;
`else
   assign state_q   = ST_RUN;
   assign clr_addr  = '0;
   assign init_done = 1'b1;
`endif

   // Reset forces every request/RAM output low even while state is held
   assign clr_active = reset_n && (state_q == ST_CLEAR);
   assign run_active = reset_n && (state_q == ST_RUN);

   distram_rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (run_active),
      .a_valid (a_req_valid),
      .b_valid (b_req_valid),
      .a_gnt   (a_gnt),
      .b_gnt   (b_gnt)
   );

   assign a_req_ready = a_gnt;
   assign b_req_ready = b_gnt;

   // RAM port mux: clear sweep, else the granted requester, else idle
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = '0;
      ram_addr = '0;
      ram_din  = '0;
      if (clr_active) begin
         ram_en   = 1'b1;
         ram_we   = '1;
         ram_addr = clr_addr;
      end else if (a_gnt) begin
         ram_en   = 1'b1;
         ram_we   = a_req_wr ? a_req_be : '0;
         ram_addr = a_req_addr;
         ram_din  = a_req_data;
      end else if (b_gnt) begin
         ram_en   = 1'b1;
         ram_we   = b_req_wr ? b_req_be : '0;
         ram_addr = b_req_addr;
         ram_din  = b_req_data;
      end
   end

   // Track the read issued this cycle so its data can be routed next cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid_q <= 1'b0;
         pend_id_q    <= REQ_A;
      end else begin
         pend_valid_q <= (a_gnt && !a_req_wr) || (b_gnt && !b_req_wr);
         if (a_gnt) begin
            pend_id_q <= REQ_A;
         end else if (b_gnt) begin
            pend_id_q <= REQ_B;
         end
      end
   end

   assign a_rsp_valid = pend_valid_q && (pend_id_q == REQ_A);
   assign b_rsp_valid = pend_valid_q && (pend_id_q == REQ_B);
   assign a_rsp_data  = a_rsp_valid ? ram_dout : '0;
   assign b_rsp_data  = b_rsp_valid ? ram_dout : '0;

endmodule

// File: tb/tb_xpm_sp_distram_arb.sv
// tb/tb_xpm_sp_distram_arb.sv - directed self-checking bench for xpm_sp_distram_arb
module tb_xpm_sp_distram_arb;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          a_req_valid, a_req_ready, a_req_wr, a_rsp_valid;
   logic [AW-1:0] a_req_addr;
   logic [DW-1:0] a_req_be, a_req_data, a_rsp_data;
   logic          b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
   logic [AW-1:0] b_req_addr;
   logic [DW-1:0] b_req_be, b_req_data, b_rsp_data;
   logic          ram_en;
   logic [DW-1:0] ram_we, ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic [AW-1:0] ram_addr;
   logic          init_done;
   logic [DW-1:0] mem [16];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xpm_sp_distram_arb #(.MEM_DATAWIDTH(DW), .MEM_ADDRWIDTH(AW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .a_req_valid (a_req_valid),
      .a_req_ready (a_req_ready),
      .a_req_wr    (a_req_wr),
      .a_req_addr  (a_req_addr),
      .a_req_be    (a_req_be),
      .a_req_data  (a_req_data),
      .a_rsp_valid (a_rsp_valid),
      .a_rsp_data  (a_rsp_data),
      .b_req_valid (b_req_valid),
      .b_req_ready (b_req_ready),
      .b_req_wr    (b_req_wr),
      .b_req_addr  (b_req_addr),
      .b_req_be    (b_req_be),
      .b_req_data  (b_req_data),
      .b_rsp_valid (b_rsp_valid),
      .b_rsp_data  (b_rsp_data),
      .ram_en      (ram_en),
      .ram_we      (ram_we),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .init_done   (init_done)
   );

   // Single-port RAM with bit write enables and one cycle read latency
   always @(posedge clk) begin
      if (ram_en) begin
         ram_dout <= mem[ram_addr];
         for (int i = 0; i < DW; i++) begin
            if (ram_we[i]) mem[ram_addr][i] <= ram_din[i];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] be, input logic [DW-1:0] data);
      a_req_valid = v;
      a_req_wr    = wr;
      a_req_addr  = addr;
      a_req_be    = be;
      a_req_data  = data;
   endtask

   task automatic drive_b(input logic v, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] be, input logic [DW-1:0] data);
      b_req_valid = v;
      b_req_wr    = wr;
      b_req_addr  = addr;
      b_req_be    = be;
      b_req_data  = data;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h77;
      reset_n = 1'b0;
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
`ifdef XPM_SP_DISTRAM_ARB_CLEAR_EN
      drive_a(1'b1, 1'b0, 4'd5, 8'h00, 8'h00);
`else
      drive_a(1'b1, 1'b0, 4'd0, 8'h00, 8'h00);
`endif
      repeat (2) tick();
      #1;
      check("rst_ram_en", ram_en, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_a_ready", a_req_ready, 0);
      check("rst_a_rsp_valid", a_rsp_valid, 0);
      check("rst_a_rsp_data", a_rsp_data, 0);
`ifdef XPM_SP_DISTRAM_ARB_CLEAR_EN
      check("rst_init_done", init_done, 0);
`else
      check("rst_init_done", init_done, 1);
`endif

      // Reset release away from the clock edge
      reset_n = 1'b1;
      #1;
`ifdef XPM_SP_DISTRAM_ARB_CLEAR_EN
      for (int i = 0; i < 16; i++) begin
         check($sformatf("clr_en_%0d", i), ram_en, 1);
         check($sformatf("clr_we_%0d", i), ram_we, 8'hFF);
         check($sformatf("clr_din_%0d", i), ram_din, 8'h00);
         check($sformatf("clr_addr_%0d", i), ram_addr, i);
         check($sformatf("clr_ready_%0d", i), a_req_ready, 0);
         check($sformatf("clr_init_%0d", i), init_done, 0);
         tick();
      end
      check("run_init_done", init_done, 1);
      check("run_a_ready", a_req_ready, 1);
      check("run_ram_addr", ram_addr, 5);
      check("run_ram_we", ram_we, 0);
      tick();
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      #1;
      check("clr_rd5_valid", a_rsp_valid, 1);
      check("clr_rd5_data", a_rsp_data, 8'h00);
`else
      check("first_a_ready", a_req_ready, 1);
      check("first_ram_en", ram_en, 1);
      check("first_ram_addr", ram_addr, 0);
      tick();
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      #1;
      check("first_rsp_valid", a_rsp_valid, 1);
`endif

      // Write from A, read-back from B on the next cycle
      drive_a(1'b1, 1'b1, 4'd3, 8'hFF, 8'hA5);
      #1;
      check("wr_a_ready", a_req_ready, 1);
      check("wr_ram_we", ram_we, 8'hFF);
      check("wr_ram_din", ram_din, 8'hA5);
      tick();
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
      #1;
      check("rd_b_ready", b_req_ready, 1);
      check("rd_ram_we", ram_we, 0);
      check("wr_no_a_rsp", a_rsp_valid, 0);
      tick();
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      #1;
      check("rd_b_rsp_valid", b_rsp_valid, 1);
      check("rd_b_rsp_data", b_rsp_data, 8'hA5);
      check("rd_a_rsp_valid", a_rsp_valid, 0);
      check("rd_a_rsp_data", a_rsp_data, 0);

      // Bit-masked write merges into the existing word
      drive_a(1'b1, 1'b1, 4'd3, 8'h0F, 8'h0F);
      #1;
      check("mask_ram_we", ram_we, 8'h0F);
      tick();
      drive_a(1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
      tick();
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      #1;
      check("mask_rsp_valid", a_rsp_valid, 1);
      check("mask_rsp_data", a_rsp_data, 8'hAF);

      // B seeds addr 7 so that B is last granted, then both contend
      drive_b(1'b1, 1'b1, 4'd7, 8'hFF, 8'h3C);
      tick();
      drive_a(1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
      drive_b(1'b1, 1'b0, 4'd7, 8'h00, 8'h00);
      #1;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("rr_a_ready_%0d", i), a_req_ready, (i % 2 == 0));
         check($sformatf("rr_b_ready_%0d", i), b_req_ready, (i % 2 == 1));
         check($sformatf("rr_ram_en_%0d", i), ram_en, 1);
         if (i > 0) begin
            check($sformatf("rr_a_rsp_%0d", i), a_rsp_valid, (i % 2 == 1));
            check($sformatf("rr_b_rsp_%0d", i), b_rsp_valid, (i % 2 == 0));
            check($sformatf("rr_a_data_%0d", i), a_rsp_data, (i % 2 == 1) ? 8'hAF : 8'h00);
            check($sformatf("rr_b_data_%0d", i), b_rsp_data, (i % 2 == 0) ? 8'h3C : 8'h00);
         end
         tick();
      end
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      #1;
      check("rr_last_b_rsp", b_rsp_valid, 1);
      check("rr_last_b_data", b_rsp_data, 8'h3C);
      check("rr_last_a_rsp", a_rsp_valid, 0);

      // Reset in the middle of a read burst with a response in flight
      drive_a(1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
      drive_b(1'b1, 1'b0, 4'd7, 8'h00, 8'h00);
      tick();
      check("mid_rsp_pending", a_rsp_valid, 1);
      reset_n = 1'b0;
      #1;
      check("mid_a_rsp_valid", a_rsp_valid, 0);
      check("mid_b_rsp_valid", b_rsp_valid, 0);
      check("mid_a_rsp_data", a_rsp_data, 0);
      check("mid_a_ready", a_req_ready, 0);
      check("mid_b_ready", b_req_ready, 0);
      check("mid_ram_en", ram_en, 0);
      check("mid_ram_we", ram_we, 0);
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      repeat (2) tick();
      reset_n = 1'b1;
      #1;
`ifdef XPM_SP_DISTRAM_ARB_CLEAR_EN
      check("reclr_init_done", init_done, 0);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("reclr_addr_%0d", i), ram_addr, i);
         check($sformatf("reclr_rsp_%0d", i), a_rsp_valid | b_rsp_valid, 0);
         tick();
      end
      check("reclr_done", init_done, 1);
`endif
      drive_a(1'b1, 1'b0, 4'd3, 8'h00, 8'h00);
      drive_b(1'b1, 1'b0, 4'd7, 8'h00, 8'h00);
      #1;
      check("post_rst_a_first", a_req_ready, 1);
      check("post_rst_b_wait", b_req_ready, 0);
      check("post_rst_no_rsp", a_rsp_valid | b_rsp_valid, 0);
      tick();
      drive_a(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      drive_b(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
